// File: rtl/pool_pkg.sv
// Shared FP16 types, constants and the small pooling helpers used by the
// 2x2 stride-2 streaming pool datapath.
package pool_pkg;

   localparam int FP16_EXP_W = 5;
   localparam int FP16_MAN_W = 10;
   localparam int FP16_BIAS  = 15;
   localparam int EXP_MAX    = 2 * FP16_BIAS + 1;

   typedef logic [15:0] fp16_t;

   localparam fp16_t QNAN = 16'h7E00;

   typedef enum logic {
      POOL_AVG = 1'b0,
      POOL_MAX = 1'b1
   } pool_mode_e;

   function automatic logic [FP16_EXP_W-1:0] fp16_exp(input fp16_t x);
      return x[FP16_MAN_W +: FP16_EXP_W];
   endfunction

   function automatic logic fp16_is_nan(input fp16_t x);
      return (&fp16_exp(x)) && (|x[FP16_MAN_W-1:0]);
   endfunction

   // Ordered key maps sign-magnitude onto two's complement so -0 and +0 tie.
   function automatic fp16_t fp16_max(input fp16_t a, input fp16_t b);
      logic signed [16:0] ka;
      logic signed [16:0] kb;
      if (fp16_is_nan(a) || fp16_is_nan(b)) begin
         return QNAN;
      end
      ka = $signed({2'b00, a[14:0]});
      kb = $signed({2'b00, b[14:0]});
      if (a[15]) ka = -ka;
      if (b[15]) kb = -kb;
      return (ka >= kb) ? a : b;
   endfunction

   function automatic fp16_t fp16_scale_quarter(input fp16_t x);
      logic [FP16_EXP_W-1:0] e;
      e = fp16_exp(x);
      if (e == FP16_EXP_W'(EXP_MAX)) begin
         return x;
      end
      if (e <= FP16_EXP_W'(2)) begin
         return {x[15], 15'd0};
      end
      return {x[15], e - FP16_EXP_W'(2), x[FP16_MAN_W-1:0]};
   endfunction

endpackage

// File: rtl/fp16_add.sv
// Combinational FP16 adder: flush-to-zero inputs and results, round to
// nearest even, signed infinity on overflow, canonical quiet NaN.
module fp16_add
   import pool_pkg::*;
(
   input  logic [15:0] a,
   input  logic [15:0] b,
   output logic [15:0] y
);

   logic              a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, swap;
   logic [15:0]       big, sml, arith;
   logic [4:0]        dexp;
   logic [24:0]       wide;
   logic [13:0]       ma_x, mb_x, norm;
   logic [14:0]       sum;
   logic [3:0]        lz;
   logic              found, round_up;
   logic [11:0]       rnd;
   logic signed [6:0] exp_n;

   assign a_zero = (fp16_exp(a) == 5'd0);
   assign b_zero = (fp16_exp(b) == 5'd0);
   assign a_nan  = fp16_is_nan(a);
   assign b_nan  = fp16_is_nan(b);
   assign a_inf  = (&fp16_exp(a)) && (a[9:0] == 10'd0);
   assign b_inf  = (&fp16_exp(b)) && (b[9:0] == 10'd0);
   assign swap   = (a[14:0] < b[14:0]);

   always_comb begin
      big   = swap ? b : a;
      sml   = swap ? a : b;
      dexp  = fp16_exp(big) - fp16_exp(sml);
      // Three extra bits below the mantissa hold guard, round and sticky.
      wide  = {1'b1, sml[9:0], 14'd0} >> dexp;
      if (dexp >= 5'd14) begin
         mb_x = 14'd1;
      end else begin
         mb_x = {wide[24:12], wide[11] | (|wide[10:0])};
      end
      ma_x = {1'b1, big[9:0], 3'd0};
      if (big[15] == sml[15]) begin
         sum = {1'b0, ma_x} + {1'b0, mb_x};
      end else begin
         sum = {1'b0, ma_x} - {1'b0, mb_x};
      end

      exp_n = $signed({2'b00, fp16_exp(big)});
      lz    = 4'd0;
      found = 1'b0;
      norm  = sum[13:0];
      if (sum[14]) begin
         norm  = {sum[14:2], sum[1] | sum[0]};
         exp_n = exp_n + 7'sd1;
      end else begin
         for (int i = 13; i >= 0; i--) begin
            if (!found && sum[i]) begin
               lz    = 4'(13 - i);
               found = 1'b1;
            end
         end
         norm  = sum[13:0] << lz;
         exp_n = exp_n - $signed({3'b000, lz});
      end

      round_up = norm[2] & (norm[3] | norm[1] | norm[0]);
      rnd      = {1'b0, norm[13:3]} + {11'd0, round_up};
      if (rnd[11]) begin
         exp_n = exp_n + 7'sd1;
      end

      if (sum == 15'd0) begin
         arith = 16'h0000;
      end else if (exp_n >= $signed(7'(EXP_MAX))) begin
         arith = {big[15], 5'h1f, 10'd0};
      end else if (exp_n <= 7'sd0) begin
         arith = {big[15], 15'd0};
      end else begin
         arith = {big[15], exp_n[4:0], rnd[11] ? 10'd0 : rnd[9:0]};
      end

      if (a_nan || b_nan) begin
         y = QNAN;
      end else if (a_inf && b_inf) begin
         y = (a[15] == b[15]) ? a : QNAN;
      end else if (a_inf) begin
         y = a;
      end else if (b_inf) begin
         y = b;
      end else if (a_zero && b_zero) begin
         y = {a[15] & b[15], 15'd0};
      end else if (a_zero) begin
         y = b;
      end else if (b_zero) begin
         y = a;
      end else begin
         y = arith;
      end
   end

endmodule

// File: rtl/pool2d_stream.sv
// Streaming 2x2 stride-2 average/max pooling over an HWC FP16 stream,
// using a per-channel hold register and one row of partial pair results.
module pool2d_stream
   import pool_pkg::*;
#(
   parameter int DEPTH  = 3,
   parameter int HEIGHT = 4,
   parameter int WIDTH  = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mode,
   input  logic        s_valid,
   output logic        s_ready,
   input  logic [15:0] s_data,
   output logic        m_valid,
   input  logic        m_ready,
   output logic [15:0] m_data,
   output logic        frame_done
);

   localparam int CH_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int COL_W = $clog2(WIDTH);
   localparam int ROW_W = $clog2(HEIGHT);
   localparam int LB_N = (WIDTH / 2) * DEPTH;
   localparam int LB_W = (LB_N > 1) ? $clog2(LB_N) : 1;

   if (HEIGHT % 2 != 0 || HEIGHT < 2) begin : g_bad_height
      $error("pool2d_stream: HEIGHT must be even");
   end
   if (WIDTH % 2 != 0 || WIDTH < 2) begin : g_bad_width
      $error("pool2d_stream: WIDTH must be even");
   end
   if (DEPTH < 1) begin : g_bad_depth
      $error("pool2d_stream: DEPTH must be at least 1");
   end

   logic [ROW_W-1:0] row_reg;
   logic [COL_W-1:0] col_reg;
   logic [CH_W-1:0]  ch_reg;
   pool_mode_e       mode_reg;

   fp16_t            hold [DEPTH];
   fp16_t            linebuf [LB_N];
   fp16_t            lb_rd_reg;

   logic             s1_valid_reg, s1_row_odd_reg, s1_last_reg;
   fp16_t            s1_p_reg;
   logic [LB_W-1:0]  s1_idx_reg;
   pool_mode_e       s1_mode_reg;

   logic             m_valid_reg, m_last_reg;
   fp16_t            m_data_reg;

   logic             advance, accept, first_beat, last_beat;
   logic             ch_wrap, col_wrap, row_wrap;
   pool_mode_e       cur_mode;
   logic [LB_W-1:0]  lb_idx;
   fp16_t            hold_sel, pair_sum, pair_p, win_sum, win_res;

   // Everything freezes while an output sits unaccepted.
   assign advance    = !(m_valid_reg && !m_ready);
   assign accept     = s_valid && advance;
   assign s_ready    = advance;
   assign m_valid    = m_valid_reg;
   assign m_data     = m_data_reg;
   assign frame_done = m_valid_reg && m_ready && m_last_reg;

   assign ch_wrap    = (ch_reg == CH_W'(DEPTH - 1));
   assign col_wrap   = (col_reg == COL_W'(WIDTH - 1));
   assign row_wrap   = (row_reg == ROW_W'(HEIGHT - 1));
   assign first_beat = (row_reg == '0) && (col_reg == '0) && (ch_reg == '0);
   assign last_beat  = row_wrap && col_wrap && ch_wrap;
   assign cur_mode   = first_beat ? pool_mode_e'(mode) : mode_reg;
   assign lb_idx     = LB_W'((int'(col_reg) / 2) * DEPTH + int'(ch_reg));
   assign hold_sel   = hold[ch_reg];

   fp16_add u_add_pair (
      .a (hold_sel),
      .b (s_data),
      .y (pair_sum)
   );

   fp16_add u_add_win (
      .a (s1_p_reg),
      .b (lb_rd_reg),
      .y (win_sum)
   );

   always_comb begin
      pair_p  = pair_sum;
      win_res = fp16_scale_quarter(win_sum);
      if (cur_mode == POOL_MAX) begin
         pair_p = fp16_max(hold_sel, s_data);
      end
      if (s1_mode_reg == POOL_MAX) begin
         win_res = fp16_max(s1_p_reg, lb_rd_reg);
      end
   end

   always_ff @(posedge clk) begin
      if (accept && !col_reg[0]) begin
         hold[ch_reg] <= s_data;
      end
   end

   // Even-row pair results are parked here until the matching odd-row pair.
   always_ff @(posedge clk) begin
      if (advance) begin
         lb_rd_reg <= linebuf[lb_idx];
         if (s1_valid_reg && !s1_row_odd_reg) begin
            linebuf[s1_idx_reg] <= s1_p_reg;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         row_reg        <= '0;
         col_reg        <= '0;
         ch_reg         <= '0;
         mode_reg       <= POOL_AVG;
         s1_valid_reg   <= 1'b0;
         s1_row_odd_reg <= 1'b0;
         s1_last_reg    <= 1'b0;
         s1_p_reg       <= '0;
         s1_idx_reg     <= '0;
         s1_mode_reg    <= POOL_AVG;
         m_valid_reg    <= 1'b0;
         m_last_reg     <= 1'b0;
         m_data_reg     <= '0;
      end else if (advance) begin
         if (accept) begin
            if (first_beat) begin
               mode_reg <= pool_mode_e'(mode);
            end
            if (ch_wrap) begin
               ch_reg <= '0;
               if (col_wrap) begin
                  col_reg <= '0;
                  row_reg <= row_wrap ? '0 : row_reg + ROW_W'(1);
               end else begin
                  col_reg <= col_reg + COL_W'(1);
               end
            end else begin
               ch_reg <= ch_reg + CH_W'(1);
            end
         end

         s1_valid_reg   <= accept && col_reg[0];
         s1_row_odd_reg <= row_reg[0];
         s1_last_reg    <= last_beat;
         s1_p_reg       <= pair_p;
         s1_idx_reg     <= lb_idx;
         s1_mode_reg    <= cur_mode;

         m_valid_reg <= s1_valid_reg && s1_row_odd_reg;
         if (s1_valid_reg && s1_row_odd_reg) begin
            m_data_reg <= win_res;
            m_last_reg <= s1_last_reg;
         end
      end
   end

endmodule
